dmem_access_guard: RTL

//  Registered, parametrised data-memory access checker in the MEM stage.

---
 rtl/dmem_access_guard.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_guard.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_guard
// Brief    : MEM-stage data-memory access checker. Flags misaligned accesses
//            and accesses outside NRGN legal regions, forwards legal accesses
//            through a one-entry valid/ready stage, and holds illegal ones as
//            a RISC-V exception (cause + tval) until the trap unit acks it.
// Options  : DAG_STATS_EN - adds saturating misalign/fault exception counters
//            on ports stat_mis / stat_flt.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_access_guard #(
    parameter int                     ADDR_W   = 32,
    parameter int                     NRGN     = 2,
    parameter logic [NRGN*ADDR_W-1:0] RGN_BASE = {32'h0000_0400, 32'h0000_0000},
    parameter logic [NRGN*6-1:0]      RGN_LOG2 = {6'd10, 6'd8}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_store,
    output logic [1:0]        out_size,
    output logic [ADDR_W-1:0] out_addr,
    output logic              exc_valid,
    output logic [3:0]        exc_cause,
    output logic [ADDR_W-1:0] exc_tval,
`ifdef DAG_STATS_EN
    output logic [15:0]       stat_mis,
    output logic [15:0]       stat_flt,
`endif
    input  logic              exc_ack
);

    localparam logic [3:0] c_cause_ld_mis = 4'd4;
    localparam logic [3:0] c_cause_ld_flt = 4'd5;
    localparam logic [3:0] c_cause_st_mis = 4'd6;
    localparam logic [3:0] c_cause_st_flt = 4'd7;

    // RUN accepts requests; TRAP blocks them while an exception is held.
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_ready;
    logic              w_is_mem;
    logic              w_misalign;
    logic [NRGN-1:0]   w_hit;
    logic              w_fault;
    logic              w_accept;
    logic              w_take_out;
    logic              w_take_exc;
    logic [3:0]        w_cause;

    logic              r_out_valid;
    logic              r_out_store;
    logic [1:0]        r_out_size;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_exc_valid;
    logic [3:0]        r_exc_cause;
    logic [ADDR_W-1:0] r_exc_tval;

    // Region hit: all address bits above the region size match the base.
    generate
        for (genvar gi = 0; gi < NRGN; gi++) begin : g_rgn
            localparam logic [ADDR_W-1:0] c_base = RGN_BASE[gi*ADDR_W +: ADDR_W];
            localparam int                c_log2 = int'(RGN_LOG2[gi*6 +: 6]);
            assign w_hit[gi] = ((req_addr ^ c_base) >> c_log2) == '0;
        end
    endgenerate

    // Alignment check; the reserved size code is reported as misaligned.
    always_comb begin
        w_misalign = 1'b0;
        case (req_size)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = req_addr[0];
            2'b10:   w_misalign = |req_addr[1:0];
            default: w_misalign = 1'b1;
        endcase
    end

    assign w_fault    = ~|w_hit;
    assign w_is_mem   = req_load | req_store;
    assign w_accept   = req_valid & w_ready;
    assign w_take_exc = w_accept & w_is_mem & (w_misalign | w_fault);
    assign w_take_out = w_accept & w_is_mem & ~w_misalign & ~w_fault;

    // Store wins over load; misalign wins over fault.
    always_comb begin
        w_cause = c_cause_ld_flt;
        if (req_store) w_cause = w_misalign ? c_cause_st_mis : c_cause_st_flt;
        else           w_cause = w_misalign ? c_cause_ld_mis : c_cause_ld_flt;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    // Next-state and request-ready decode; flush always returns to RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_ready = ~flush & (~r_out_valid | out_ready);
                if (w_take_exc) w_state_nxt = ST_TRAP;
            end
            ST_TRAP: begin
                if (exc_ack) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
        if (flush) w_state_nxt = ST_RUN;
    end

    // Output stage: load on legal accept, empty on drain, held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_store <= 1'b0;
            r_out_size  <= 2'b00;
            r_out_addr  <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_take_out) begin
            r_out_valid <= 1'b1;
            r_out_store <= req_store;
            r_out_size  <= req_size;
            r_out_addr  <= req_addr;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Exception holder: latched on illegal accept, cleared by ack or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exc_valid <= 1'b0;
            r_exc_cause <= 4'd0;
            r_exc_tval  <= '0;
        end else if (flush) begin
            r_exc_valid <= 1'b0;
        end else if (w_take_exc) begin
            r_exc_valid <= 1'b1;
            r_exc_cause <= w_cause;
            r_exc_tval  <= req_addr;
        end else if (r_exc_valid & exc_ack) begin
            r_exc_valid <= 1'b0;
        end
    end

`ifdef DAG_STATS_EN
    logic [15:0] r_stat_mis;
    logic [15:0] r_stat_flt;

    // Saturating exception counters; deliberately untouched by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_mis <= 16'h0000;
            r_stat_flt <= 16'h0000;
        end else if (w_take_exc) begin
            if (w_misalign) begin
                if (r_stat_mis != 16'hFFFF) r_stat_mis <= r_stat_mis + 16'h0001;
            end else begin
                if (r_stat_flt != 16'hFFFF) r_stat_flt <= r_stat_flt + 16'h0001;
            end
        end
    end

    assign stat_mis = r_stat_mis;
    assign stat_flt = r_stat_flt;
`endif

    assign req_ready = w_ready;
    assign out_valid = r_out_valid;
    assign out_store = r_out_store;
    assign out_size  = r_out_size;
    assign out_addr  = r_out_addr;
    assign exc_valid = r_exc_valid;
    assign exc_cause = r_exc_cause;
    assign exc_tval  = r_exc_tval;

endmodule
`default_nettype wire
